atm_bank_host: RTL

Bank-side responder for the ATM controller: accepts one request at a time (PIN verify, OTP verify, balance, withdraw, deposit, end session) over a valid/ready request channel. It answers each request with a status and a balance over a valid/ready response channel. It holds a small account table (PIN, balance, failed-attempt count, blocked flag) and the state of the one active session. It is the authority the ATM front-end queries before dispensing or crediting.

---
 rtl/atm_bank_host.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/atm_bank_host.sv
// Bank-side responder for the ATM controller: validates PINs/OTPs, keeps the
// account table and the single active session, and answers one request at a time.
module atm_bank_host #(
  parameter int unsigned NUM_ACCOUNTS     = 4,
  parameter int unsigned INIT_BALANCE     = 5000,
  parameter logic [3:0]  PIN_BASE         = 4'h0,
  parameter logic [15:0] OTP_CODE         = 16'h1234,
  parameter int unsigned MAX_ATTEMPTS     = 3,
  parameter int unsigned WITHDRAWAL_LIMIT = 10000,
  localparam int unsigned ACCT_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_cmd,
  input  logic [ACCT_W-1:0]       req_acct,
  input  logic [3:0]              req_pin,
  input  logic [15:0]             req_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [2:0]              resp_status,
  output logic [15:0]             resp_balance,
  output logic                    session_active,
  output logic [NUM_ACCOUNTS-1:0] acct_blocked
);

  localparam int unsigned ATT_W = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS + 1) : 1;
  localparam int unsigned BAL_W = 16;
  localparam int unsigned WD_W  = 17;

  localparam logic [2:0] CMD_VERIFY_PIN = 3'd0;
  localparam logic [2:0] CMD_VERIFY_OTP = 3'd1;
  localparam logic [2:0] CMD_BALANCE    = 3'd2;
  localparam logic [2:0] CMD_WITHDRAW   = 3'd3;
  localparam logic [2:0] CMD_DEPOSIT    = 3'd4;
  localparam logic [2:0] CMD_END        = 3'd5;

  localparam logic [2:0] ST_OK         = 3'd0;
  localparam logic [2:0] ST_BAD_PIN    = 3'd1;
  localparam logic [2:0] ST_BLOCKED    = 3'd2;
  localparam logic [2:0] ST_NO_AUTH    = 3'd3;
  localparam logic [2:0] ST_BAD_OTP    = 3'd4;
  localparam logic [2:0] ST_NO_FUNDS   = 3'd5;
  localparam logic [2:0] ST_OVER_LIMIT = 3'd6;
  localparam logic [2:0] ST_ERROR      = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                  r_state, w_state_n;

  logic [2:0]              r_cmd;
  logic [ACCT_W-1:0]       r_acct;
  logic [3:0]              r_pin;
  logic [15:0]             r_data;

  logic [BAL_W-1:0]        r_balance  [NUM_ACCOUNTS];
  logic [ATT_W-1:0]        r_attempts [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] r_blocked;

  logic                    r_auth;
  logic [ACCT_W-1:0]       r_sess_acct;
  logic                    r_otp_ok;
  logic [WD_W-1:0]         r_withdrawn;

  logic [2:0]              r_status;
  logic [BAL_W-1:0]        r_resp_bal;

  logic                    w_acct_ok;
  logic [3:0]              w_exp_pin;
  logic [ATT_W-1:0]        w_att_inc;
  logic [BAL_W-1:0]        w_sess_bal;
  logic [WD_W-1:0]         w_wd_sum;
  logic [WD_W-1:0]         w_dep_sum;

  logic [2:0]              w_status;
  logic [BAL_W-1:0]        w_resp_bal;
  logic                    w_auth_n;
  logic [ACCT_W-1:0]       w_sess_acct_n;
  logic                    w_otp_n;
  logic [WD_W-1:0]         w_wd_n;
  logic                    w_bal_we;
  logic [BAL_W-1:0]        w_bal_val;
  logic                    w_att_we;
  logic [ATT_W-1:0]        w_att_val;
  logic                    w_blk_set;

  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = (r_state == S_RESP);
  assign resp_status    = r_status;
  assign resp_balance   = r_resp_bal;
  assign session_active = r_auth;
  assign acct_blocked   = r_blocked;

  assign w_acct_ok  = 32'(r_acct) < NUM_ACCOUNTS;
  assign w_exp_pin  = PIN_BASE + 4'(r_acct);
  assign w_att_inc  = r_attempts[r_acct] + ATT_W'(1);
  assign w_sess_bal = r_balance[r_sess_acct];
  assign w_wd_sum   = r_withdrawn + WD_W'(r_data);
  assign w_dep_sum  = WD_W'(w_sess_bal) + WD_W'(r_data);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)  w_state_n = S_EXEC;
      S_EXEC:                  w_state_n = S_RESP;
      S_RESP:  if (resp_ready) w_state_n = S_IDLE;
      default:                 w_state_n = S_IDLE;
    endcase
  end

  // Command evaluation during EXEC: status, response balance and table/session updates.
  always_comb begin
    w_status      = ST_ERROR;
    w_resp_bal    = '0;
    w_auth_n      = r_auth;
    w_sess_acct_n = r_sess_acct;
    w_otp_n       = r_otp_ok;
    w_wd_n        = r_withdrawn;
    w_bal_we      = 1'b0;
    w_bal_val     = w_sess_bal;
    w_att_we      = 1'b0;
    w_att_val     = '0;
    w_blk_set     = 1'b0;
    case (r_cmd)
      CMD_VERIFY_PIN: begin
        w_auth_n = 1'b0;
        w_otp_n  = 1'b0;
        w_wd_n   = '0;
        if (!w_acct_ok) begin
          w_status = ST_ERROR;
        end else if (r_blocked[r_acct]) begin
          w_status = ST_BLOCKED;
        end else if (r_pin == w_exp_pin) begin
          w_status      = ST_OK;
          w_att_we      = 1'b1;
          w_auth_n      = 1'b1;
          w_sess_acct_n = r_acct;
          w_resp_bal    = r_balance[r_acct];
        end else begin
          w_att_we = 1'b1;
          if (32'(w_att_inc) >= MAX_ATTEMPTS) begin
            w_blk_set = 1'b1;
            w_status  = ST_BLOCKED;
          end else begin
            w_att_val = w_att_inc;
            w_status  = ST_BAD_PIN;
          end
        end
      end
      CMD_VERIFY_OTP: begin
        if (!r_auth) begin
          w_status = ST_NO_AUTH;
        end else if (r_data == OTP_CODE) begin
          w_status = ST_OK;
          w_otp_n  = 1'b1;
        end else begin
          w_status = ST_BAD_OTP;
          w_otp_n  = 1'b0;
        end
      end
      CMD_BALANCE: begin
        if (!r_auth) begin
          w_status = ST_NO_AUTH;
        end else begin
          w_status   = ST_OK;
          w_resp_bal = w_sess_bal;
        end
      end
      CMD_WITHDRAW: begin
        if (!r_auth)                              w_status = ST_NO_AUTH;
        else if (!r_otp_ok)                       w_status = ST_BAD_OTP;
        else if (r_data == '0)                    w_status = ST_ERROR;
        else if (w_wd_sum > WD_W'(WITHDRAWAL_LIMIT)) w_status = ST_OVER_LIMIT;
        else if (r_data > w_sess_bal)             w_status = ST_NO_FUNDS;
        else begin
          w_status   = ST_OK;
          w_bal_we   = 1'b1;
          w_bal_val  = w_sess_bal - r_data;
          w_wd_n     = w_wd_sum;
          w_otp_n    = 1'b0;
          w_resp_bal = w_sess_bal - r_data;
        end
      end
      CMD_DEPOSIT: begin
        if (!r_auth)              w_status = ST_NO_AUTH;
        else if (r_data == '0)    w_status = ST_ERROR;
        else if (w_dep_sum[16])   w_status = ST_ERROR;
        else begin
          w_status   = ST_OK;
          w_bal_we   = 1'b1;
          w_bal_val  = w_dep_sum[15:0];
          w_resp_bal = w_dep_sum[15:0];
        end
      end
      CMD_END: begin
        w_status = ST_OK;
        w_auth_n = 1'b0;
        w_otp_n  = 1'b0;
        w_wd_n   = '0;
      end
      default: w_status = ST_ERROR;
    endcase
  end

  // Request capture, table/session commit and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd       <= '0;
      r_acct      <= '0;
      r_pin       <= '0;
      r_data      <= '0;
      r_blocked   <= '0;
      r_auth      <= 1'b0;
      r_sess_acct <= '0;
      r_otp_ok    <= 1'b0;
      r_withdrawn <= '0;
      r_status    <= '0;
      r_resp_bal  <= '0;
      for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
        r_balance[i]  <= BAL_W'(INIT_BALANCE);
        r_attempts[i] <= '0;
      end
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_cmd  <= req_cmd;
        r_acct <= req_acct;
        r_pin  <= req_pin;
        r_data <= req_data;
      end
      if (r_state == S_EXEC) begin
        r_auth      <= w_auth_n;
        r_sess_acct <= w_sess_acct_n;
        r_otp_ok    <= w_otp_n;
        r_withdrawn <= w_wd_n;
        r_status    <= w_status;
        r_resp_bal  <= w_resp_bal;
        if (w_bal_we)  r_balance[r_sess_acct] <= w_bal_val;
        if (w_att_we)  r_attempts[r_acct]     <= w_att_val;
        if (w_blk_set) r_blocked[r_acct]      <= 1'b1;
      end
    end
  end

endmodule
